// File: rtl/seg7_pkg.sv
// Shared definitions for the message-fed 7-seg scroller: active-low glyph codes {g,f,e,d,c,b,a}
// and the message source state encoding.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_t;

  localparam logic [6:0] CHAR_0 = 7'b1000000;
  localparam logic [6:0] CHAR_1 = 7'b1111001;
  localparam logic [6:0] CHAR_2 = 7'b0100100;
  localparam logic [6:0] CHAR_3 = 7'b0110000;
  localparam logic [6:0] CHAR_4 = 7'b0011001;
  localparam logic [6:0] CHAR_5 = 7'b0010010;
  localparam logic [6:0] CHAR_6 = 7'b0000010;
  localparam logic [6:0] CHAR_7 = 7'b1111000;
  localparam logic [6:0] CHAR_8 = 7'b0000000;
  localparam logic [6:0] CHAR_9 = 7'b0010000;
  localparam logic [6:0] CHAR_A = 7'b0001000;
  localparam logic [6:0] CHAR_B = 7'b0000000;
  localparam logic [6:0] CHAR_U = 7'b1000001;
  localparam logic [6:0] DASH   = 7'b0111111;
  localparam logic [6:0] SPACE  = 7'b1111111;

endpackage

// File: rtl/seg7_ascii_enc.sv
// Combinational ASCII to active-low 7-seg encoder; lowercase folds to uppercase and
// anything without a glyph comes out blank.
module seg7_ascii_enc
  import seg7_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [6:0] code
);

  logic [7:0] upper;

  always_comb begin
    upper = ascii;
    if (ascii >= 8'h61 && ascii <= 8'h7A) begin
      upper = ascii - 8'h20;
    end
  end

  always_comb begin
    code = SPACE;
    case (upper)
      8'h30:   code = CHAR_0;
      8'h31:   code = CHAR_1;
      8'h32:   code = CHAR_2;
      8'h33:   code = CHAR_3;
      8'h34:   code = CHAR_4;
      8'h35:   code = CHAR_5;
      8'h36:   code = CHAR_6;
      8'h37:   code = CHAR_7;
      8'h38:   code = CHAR_8;
      8'h39:   code = CHAR_9;
      8'h41:   code = CHAR_A;
      8'h42:   code = CHAR_B;
      8'h55:   code = CHAR_U;
      8'h2D:   code = DASH;
      default: code = SPACE;
    endcase
  end

endmodule

// File: rtl/scroll_msg_source.sv
// Message source for the 7-seg scroller: loads an encoded message over valid/ready, then
// replays it cyclically per consumer step. Optional per-char LED storage via SCROLL_LED_EN.
//
// state | meaning
// IDLE  | buffer empty, waiting for the first char
// LOAD  | chars arriving, message not yet closed
// PLAY  | message closed, replaying one code per step
module scroll_msg_source
  import seg7_pkg::*;
#(
  parameter  int MAX_LEN = 16,
  localparam int PTR_W   = $clog2(MAX_LEN),
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             real_clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_char,
  input  logic             wr_last,
  input  logic             wr_led,
  input  logic             step,
  output logic [6:0]       seg_code,
  output logic             seg_valid,
  output logic             led_bit,
  output logic [LEN_W-1:0] msg_len
);

  state_t           state, next_state;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [6:0]       code_mem [MAX_LEN];
  logic [6:0]       enc_code;
  logic             wr_fire;
  logic             close_msg;
  logic             play;

  seg7_ascii_enc u_enc (
    .ascii (wr_char),
    .code  (enc_code)
  );

  assign play      = (state == PLAY);
  assign wr_ready  = !play;
  assign wr_fire   = wr_valid && wr_ready && !clr;
  assign close_msg = wr_last || (wr_ptr == PTR_W'(MAX_LEN - 1));

  always_ff @(posedge real_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (clr) begin
      next_state = IDLE;
    end else if (wr_fire) begin
      next_state = close_msg ? PLAY : LOAD;
    end
  end

  always_ff @(posedge real_clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      msg_len <= '0;
    end else if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      msg_len <= '0;
    end else if (wr_fire) begin
      if (close_msg) begin
        // Write side restarts at 0 so the next load after clr lines up with rd side.
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        msg_len <= LEN_W'(wr_ptr) + LEN_W'(1);
      end else begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
    end else if (play && step) begin
      if (LEN_W'(rd_ptr) == msg_len - LEN_W'(1)) rd_ptr <= '0;
      else                                      rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge real_clk) begin
    if (wr_fire) code_mem[wr_ptr] <= enc_code;
  end

  assign seg_valid = play;
  assign seg_code  = play ? code_mem[rd_ptr] : SPACE;

`ifdef SCROLL_LED_EN
  logic led_mem [MAX_LEN];

  always_ff @(posedge real_clk) begin
    if (wr_fire) led_mem[wr_ptr] <= wr_led;
  end

  assign led_bit = play ? led_mem[rd_ptr] : 1'b0;
`else
  logic unused_wr_led;

  assign unused_wr_led = wr_led;
  assign led_bit       = 1'b0;
`endif

endmodule

// File: tb/tb_scroll_msg_source.sv
// Self-checking bench for scroll_msg_source; expected codes queued at write time and
// replayed cyclically against seg_code/led_bit on each consumer step.
module tb_scroll_msg_source;

  logic       real_clk = 1'b0;
  logic       rst      = 1'b1;
  logic       clr      = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_char  = 8'h00;
  logic       wr_last  = 1'b0;
  logic       wr_led   = 1'b0;
  logic       step     = 1'b0;
  logic [6:0] seg_code;
  logic       seg_valid;
  logic       led_bit;
  logic [4:0] msg_len;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];

  scroll_msg_source #(.MAX_LEN(16)) dut (
    .real_clk  (real_clk),
    .rst       (rst),
    .clr       (clr),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_char   (wr_char),
    .wr_last   (wr_last),
    .wr_led    (wr_led),
    .step      (step),
    .seg_code  (seg_code),
    .seg_valid (seg_valid),
    .led_bit   (led_bit),
    .msg_len   (msg_len)
  );

  always #5 real_clk = ~real_clk;

  function automatic logic [6:0] ref_enc(input logic [7:0] c);
    case (c)
      "0": return 7'b1000000;  "1": return 7'b1111001;  "2": return 7'b0100100;
      "3": return 7'b0110000;  "4": return 7'b0011001;  "5": return 7'b0010010;
      "6": return 7'b0000010;  "7": return 7'b1111000;  "8": return 7'b0000000;
      "9": return 7'b0010000;  "A", "a": return 7'b0001000;
      "B", "b": return 7'b0000000;  "U", "u": return 7'b1000001;
      "-": return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic led_exp(input logic l);
`ifdef SCROLL_LED_EN
    return l;
`else
    return 1'b0 & l;
`endif
  endfunction

  task automatic do_write(input logic [7:0] c, input logic last, input logic led);
    @(negedge real_clk);
    wr_valid = 1'b1; wr_char = c; wr_last = last; wr_led = led;
    @(posedge real_clk); #1;
    wr_valid = 1'b0; wr_last = 1'b0; wr_led = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge real_clk); clr = 1'b1;
    @(posedge real_clk); #1; clr = 1'b0;
    exp_q.delete();
  endtask

  task automatic load_msg(input string s, input logic [15:0] leds, input logic last_on_end);
    do_clr();
    for (int i = 0; i < s.len(); i++) begin
      exp_q.push_back({led_exp(leds[i]), ref_enc(s[i])});
      do_write(s[i], last_on_end && (i == s.len() - 1), leds[i]);
    end
  endtask

  task automatic play_check(input string name, input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge real_clk);
      e = exp_q.pop_front();
      exp_q.push_back(e);
      total++;
      if (seg_code !== e[6:0] || led_bit !== e[7] || seg_valid !== 1'b1) begin
        bad++;
        $display("FAIL %s step%0d: got code=%b led=%b valid=%b want code=%b led=%b valid=1",
                 name, i, seg_code, led_bit, seg_valid, e[6:0], e[7]);
      end
      step = 1'b1;
      @(posedge real_clk); #1; step = 1'b0;
    end
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if (seg_code !== 7'h7F || seg_valid !== 1'b0 || wr_ready !== 1'b1 ||
        led_bit !== 1'b0 || msg_len !== 5'd0) begin
      bad++;
      $display("FAIL %s: got code=%h valid=%b ready=%b led=%b len=%0d want 7f/0/1/0/0",
               name, seg_code, seg_valid, wr_ready, led_bit, msg_len);
    end
  endtask

  task automatic test_reset();
    #1 check_idle_outputs("reset_held");
    #12 rst = 1'b0;
    @(posedge real_clk); #1;
    check_idle_outputs("reset_released");
  endtask

  task automatic test_buaa();
    load_msg("BUAA", 16'h0000, 1'b1);
    total++;
    if (msg_len !== 5'd4 || wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL buaa_len: got len=%0d ready=%b want 4/0", msg_len, wr_ready);
    end
    play_check("buaa", 5);
  endtask

  task automatic test_full_buffer();
    string s = "0123456789ABU- b";
    do_clr();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        total++;
        if (wr_ready !== 1'b1 || seg_valid !== 1'b0) begin
          bad++;
          $display("FAIL full_pre16: got ready=%b valid=%b want 1/0", wr_ready, seg_valid);
        end
      end
      exp_q.push_back({1'b0, ref_enc(s[i])});
      do_write(s[i], 1'b0, 1'b0);
    end
    total++;
    if (seg_valid !== 1'b1 || wr_ready !== 1'b0 || msg_len !== 5'd16) begin
      bad++;
      $display("FAIL full_play: got valid=%b ready=%b len=%0d want 1/0/16",
               seg_valid, wr_ready, msg_len);
    end
    do_write("1", 1'b1, 1'b1);
    total++;
    if (msg_len !== 5'd16 || seg_code !== 7'b1000000) begin
      bad++;
      $display("FAIL full_17th: got len=%0d code=%b want 16/1000000", msg_len, seg_code);
    end
    play_check("full", 18);
  endtask

  task automatic test_single_char();
    load_msg("5", 16'h0000, 1'b1);
    total++;
    if (msg_len !== 5'd1) begin
      bad++;
      $display("FAIL single_len: got %0d want 1", msg_len);
    end
    play_check("single", 4);
  endtask

  task automatic test_clr_priority();
    load_msg("AB", 16'h0000, 1'b1);
    play_check("pre_clr", 1);
    @(negedge real_clk); clr = 1'b1; step = 1'b1;
    @(posedge real_clk); #1; clr = 1'b0; step = 1'b0;
    check_idle_outputs("clr_step");
    @(negedge real_clk); clr = 1'b1; wr_valid = 1'b1; wr_char = "9"; wr_last = 1'b1;
    #1;
    total++;
    if (wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL clr_wr_ready: got %b want 1", wr_ready);
    end
    @(posedge real_clk); #1; clr = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
    check_idle_outputs("clr_write_dropped");
  endtask

  task automatic test_encoding();
    load_msg("Z-", 16'h0000, 1'b1);
    play_check("z_dash", 3);
    load_msg("b", 16'h0000, 1'b1);
    total++;
    if (seg_code !== 7'b0000000) begin
      bad++;
      $display("FAIL lower_b: got %b want 0000000", seg_code);
    end
    load_msg("2U9", 16'h0000, 1'b1);
    play_check("digits", 4);
  endtask

  task automatic test_led_and_rst();
    load_msg("AU1", 16'b0000_0000_0000_0101, 1'b1);
    play_check("led", 5);
    @(negedge real_clk); #2 rst = 1'b1;
    #1 check_idle_outputs("rst_mid_play");
    @(negedge real_clk); rst = 1'b0;
    @(posedge real_clk); #1;
    check_idle_outputs("rst_after");
  endtask

  initial begin
    test_reset();
    test_buaa();
    test_full_buffer();
    test_single_char();
    test_clr_priority();
    test_encoding();
    test_led_and_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
